// File: rtl/id_stage_pkg.sv
// Shared definitions for the decode stage: widths, ALU op codes,
// instruction opcodes, instruction field positions and small helpers.
package id_stage_pkg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 4;

    // ALU operation codes presented to the execute stage
    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_XOR = 3'd3,
        ALU_SLL = 3'd4,
        ALU_SRL = 3'd5,
        ALU_COM = 3'd6,
        ALU_MUL = 3'd7
    } alu_op_e;

    // Instruction opcodes (instr[31:28]); 11..15 are illegal
    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_XOR  = 4'd3;
    localparam logic [3:0] OP_COM  = 4'd4;
    localparam logic [3:0] OP_MUL  = 4'd5;
    localparam logic [3:0] OP_ADDI = 4'd6;
    localparam logic [3:0] OP_SLLI = 4'd7;
    localparam logic [3:0] OP_SRLI = 4'd8;
    localparam logic [3:0] OP_LW   = 4'd9;
    localparam logic [3:0] OP_SW   = 4'd10;

    // Instruction field bit positions
    localparam int OP_MSB  = 31;
    localparam int OP_LSB  = 28;
    localparam int RD_MSB  = 27;
    localparam int RD_LSB  = 24;
    localparam int RS_MSB  = 23;
    localparam int RS_LSB  = 20;
    localparam int RT_MSB  = 19;
    localparam int RT_LSB  = 16;
    localparam int IMM_MSB = 15;
    localparam int IMM_LSB = 0;

    // Sign-extend a 16-bit immediate to the datapath width
    function automatic logic [DATA_W-1:0] sext16(input logic [15:0] imm);
        return {{(DATA_W-16){imm[15]}}, imm};
    endfunction

endpackage

// File: rtl/id_stage_hazard_unit.sv
// Load-use hazard detection: compares the decoding instruction's source
// registers against the destination of a load sitting in ID/EX.
module hazard_unit
    import id_stage_pkg::*;
#(
    parameter int RBITS = REG_W
) (
    input  logic [RBITS-1:0] rs,
    input  logic [RBITS-1:0] rt,
    input  logic             use_rs,
    input  logic             use_rt,
    input  logic [RBITS-1:0] ex_rd,
    input  logic             ex_mem_read,
    input  logic             ex_valid,
    input  logic             flush,
    input  logic             instr_valid,
    output logic             stall
);

    logic load_in_ex;
    logic src_match;

    // Stall only when a live load in EX writes a register this instruction reads
    always_comb begin
        load_in_ex = ex_valid && ex_mem_read && (ex_rd != '0);
        src_match  = (use_rs && (ex_rd == rs)) || (use_rt && (ex_rd == rt));
        stall      = instr_valid && use_rs && !flush && load_in_ex && src_match;
    end

endmodule

// File: rtl/id_stage.sv
// Instruction decode stage: decodes the fetched instruction, selects ALU
// operands from the register file and immediate, and registers the result
// into the ID/EX pipeline register. Load-use hazards insert one bubble.
module id_stage
    import id_stage_pkg::*;
#(
    parameter int DSIZE = DATA_W,
    parameter int RBITS = REG_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      instr,
    input  logic             instr_valid,
    input  logic             flush,
    output logic [RBITS-1:0] rs_addr,
    output logic [RBITS-1:0] rt_addr,
    input  logic [DSIZE-1:0] rs_data,
    input  logic [DSIZE-1:0] rt_data,
    output logic             stall,
    output logic             ex_valid,
    output logic [2:0]       ex_alu_op,
    output logic [DSIZE-1:0] ex_a,
    output logic [DSIZE-1:0] ex_b,
    output logic [DSIZE-1:0] ex_store_data,
    output logic [RBITS-1:0] ex_rs,
    output logic [RBITS-1:0] ex_rt,
    output logic [RBITS-1:0] ex_rd,
    output logic             ex_reg_write,
    output logic             ex_mem_read,
    output logic             ex_mem_write,
    output logic             err_illegal
);

    logic [3:0]       op;
    logic [RBITS-1:0] rd;
    logic [15:0]      imm;
    logic             legal;
    logic             use_rt;
    alu_op_e          alu_dec;
    logic [DSIZE-1:0] b_dec;
    logic             reg_write_dec;
    logic             mem_read_dec;
    logic             mem_write_dec;
    logic             issue;
    logic             illegal_seen;

    assign op      = instr[OP_MSB:OP_LSB];
    assign rd      = instr[RD_MSB:RD_LSB];
    assign rs_addr = instr[RS_MSB:RS_LSB];
    assign rt_addr = instr[RT_MSB:RT_LSB];
    assign imm     = instr[IMM_MSB:IMM_LSB];

    // Opcode decode: ALU op, operand b source and control bits
    always_comb begin
        legal         = 1'b1;
        use_rt        = 1'b0;
        alu_dec       = ALU_ADD;
        b_dec         = rt_data;
        reg_write_dec = 1'b0;
        mem_read_dec  = 1'b0;
        mem_write_dec = 1'b0;
        case (op)
            OP_ADD:  begin alu_dec = ALU_ADD; use_rt = 1'b1; reg_write_dec = 1'b1; end
            OP_SUB:  begin alu_dec = ALU_SUB; use_rt = 1'b1; reg_write_dec = 1'b1; end
            OP_AND:  begin alu_dec = ALU_AND; use_rt = 1'b1; reg_write_dec = 1'b1; end
            OP_XOR:  begin alu_dec = ALU_XOR; use_rt = 1'b1; reg_write_dec = 1'b1; end
            OP_COM:  begin alu_dec = ALU_COM; use_rt = 1'b1; reg_write_dec = 1'b1; end
            OP_MUL:  begin alu_dec = ALU_MUL; use_rt = 1'b1; reg_write_dec = 1'b1; end
            OP_ADDI: begin b_dec = sext16(imm); reg_write_dec = 1'b1; end
            OP_SLLI: begin alu_dec = ALU_SLL; b_dec = {{(DSIZE-5){1'b0}}, imm[4:0]}; reg_write_dec = 1'b1; end
            OP_SRLI: begin alu_dec = ALU_SRL; b_dec = {{(DSIZE-5){1'b0}}, imm[4:0]}; reg_write_dec = 1'b1; end
            OP_LW:   begin b_dec = sext16(imm); mem_read_dec = 1'b1; reg_write_dec = 1'b1; end
            OP_SW:   begin b_dec = sext16(imm); use_rt = 1'b1; mem_write_dec = 1'b1; end
            default: legal = 1'b0;
        endcase
    end

    hazard_unit #(.RBITS(RBITS)) u_hazard (
        .rs          (rs_addr),
        .rt          (rt_addr),
        .use_rs      (legal),
        .use_rt      (use_rt),
        .ex_rd       (ex_rd),
        .ex_mem_read (ex_mem_read),
        .ex_valid    (ex_valid),
        .flush       (flush),
        .instr_valid (instr_valid),
        .stall       (stall)
    );

    assign issue        = instr_valid && legal && !flush && !stall;
    assign illegal_seen = instr_valid && !legal && !flush;

    // ID/EX register: load the decoded instruction or a fully cleared bubble
    always_ff @(posedge clk or posedge rst) begin
        if (rst || !issue) begin
            ex_valid      <= 1'b0;
            ex_alu_op     <= '0;
            ex_a          <= '0;
            ex_b          <= '0;
            ex_store_data <= '0;
            ex_rs         <= '0;
            ex_rt         <= '0;
            ex_rd         <= '0;
            ex_reg_write  <= 1'b0;
            ex_mem_read   <= 1'b0;
            ex_mem_write  <= 1'b0;
        end else begin
            ex_valid      <= 1'b1;
            ex_alu_op     <= alu_dec;
            ex_a          <= rs_data;
            ex_b          <= b_dec;
            ex_store_data <= rt_data;
            ex_rs         <= rs_addr;
            ex_rt         <= rt_addr;
            ex_rd         <= rd;
            ex_reg_write  <= reg_write_dec && (rd != '0);
            ex_mem_read   <= mem_read_dec;
            ex_mem_write  <= mem_write_dec;
        end
    end

    // Sticky illegal-opcode flag, cleared only by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_illegal <= 1'b0;
        end else if (illegal_seen) begin
            err_illegal <= 1'b1;
        end
    end

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: a literal vector table, hand-written
// hazard/illegal/reset sequences, and randomized traffic against a model.
module tb_id_stage;
    import id_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic        instr_valid;
    logic        flush;
    logic [3:0]  rs_addr, rt_addr;
    logic [31:0] rs_data, rt_data;
    logic        stall;
    logic        ex_valid;
    logic [2:0]  ex_alu_op;
    logic [31:0] ex_a, ex_b, ex_store_data;
    logic [3:0]  ex_rs, ex_rt, ex_rd;
    logic        ex_reg_write, ex_mem_read, ex_mem_write;
    logic        err_illegal;

    int compared   = 0;
    int mismatched = 0;

    typedef struct packed {
        logic        valid;
        logic [2:0]  alu;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] sd;
        logic [3:0]  rs;
        logic [3:0]  rt;
        logic [3:0]  rd;
        logic        rw;
        logic        mr;
        logic        mw;
    } ex_t;

    typedef struct {
        logic [31:0] ins;
        logic        v;
        logic        f;
        logic [31:0] ra;
        logic [31:0] rb;
        logic        stl;
        logic        vld;
        logic [2:0]  alu;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] sd;
        logic [3:0]  rs;
        logic [3:0]  rd;
        logic        rw;
        logic        mr;
        logic        mw;
    } vec_t;

    ex_t  model;
    logic model_err;
    logic last_stall;

    id_stage dut (
        .clk           (clk),
        .rst           (rst),
        .instr         (instr),
        .instr_valid   (instr_valid),
        .flush         (flush),
        .rs_addr       (rs_addr),
        .rt_addr       (rt_addr),
        .rs_data       (rs_data),
        .rt_data       (rt_data),
        .stall         (stall),
        .ex_valid      (ex_valid),
        .ex_alu_op     (ex_alu_op),
        .ex_a          (ex_a),
        .ex_b          (ex_b),
        .ex_store_data (ex_store_data),
        .ex_rs         (ex_rs),
        .ex_rt         (ex_rt),
        .ex_rd         (ex_rd),
        .ex_reg_write  (ex_reg_write),
        .ex_mem_read   (ex_mem_read),
        .ex_mem_write  (ex_mem_write),
        .err_illegal   (err_illegal)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] enc(int op, int rd, int rs, int rt, int imm);
        return {4'(op), 4'(rd), 4'(rs), 4'(rt), 16'(imm)};
    endfunction

    function automatic vec_t mkVec(logic [31:0] ins, logic v, logic f, logic [31:0] ra,
                                   logic [31:0] rb, logic stl, logic vld, logic [2:0] alu,
                                   logic [31:0] a, logic [31:0] b, logic [31:0] sd,
                                   logic [3:0] rs, logic [3:0] rd, logic rw, logic mr, logic mw);
        vec_t r;
        r.ins = ins; r.v = v; r.f = f; r.ra = ra; r.rb = rb; r.stl = stl; r.vld = vld;
        r.alu = alu; r.a = a; r.b = b; r.sd = sd; r.rs = rs; r.rd = rd;
        r.rw = rw; r.mr = mr; r.mw = mw;
        return r;
    endfunction

    // Reference: what ID/EX should hold after one edge, from the ISA rules
    function automatic ex_t modelStep(ex_t cur, logic [31:0] ins, logic v, logic f,
                                      logic [31:0] ra, logic [31:0] rb, output logic stl);
        ex_t        nxt;
        int         op;
        logic [3:0] rd, rs, rt;
        logic       legal, uses_rt;
        op = int'(ins[31:28]);
        rd = ins[27:24];
        rs = ins[23:20];
        rt = ins[19:16];
        legal   = (op <= 10);
        uses_rt = (op <= 5) || (op == 10);
        stl = v && legal && !f && cur.valid && cur.mr && (cur.rd != 0) &&
              ((cur.rd == rs) || (uses_rt && (cur.rd == rt)));
        nxt = '0;
        if (v && legal && !f && !stl) begin
            nxt.valid = 1'b1;
            nxt.a  = ra;
            nxt.sd = rb;
            nxt.rs = rs;
            nxt.rt = rt;
            nxt.rd = rd;
            case (op)
                0: begin nxt.alu = ALU_ADD; nxt.b = rb; nxt.rw = 1'b1; end
                1: begin nxt.alu = ALU_SUB; nxt.b = rb; nxt.rw = 1'b1; end
                2: begin nxt.alu = ALU_AND; nxt.b = rb; nxt.rw = 1'b1; end
                3: begin nxt.alu = ALU_XOR; nxt.b = rb; nxt.rw = 1'b1; end
                4: begin nxt.alu = ALU_COM; nxt.b = rb; nxt.rw = 1'b1; end
                5: begin nxt.alu = ALU_MUL; nxt.b = rb; nxt.rw = 1'b1; end
                6: begin nxt.alu = ALU_ADD; nxt.b = 32'(signed'(ins[15:0])); nxt.rw = 1'b1; end
                7: begin nxt.alu = ALU_SLL; nxt.b = 32'(ins[4:0]); nxt.rw = 1'b1; end
                8: begin nxt.alu = ALU_SRL; nxt.b = 32'(ins[4:0]); nxt.rw = 1'b1; end
                9: begin nxt.alu = ALU_ADD; nxt.b = 32'(signed'(ins[15:0])); nxt.rw = 1'b1; nxt.mr = 1'b1; end
                default: begin nxt.alu = ALU_ADD; nxt.b = 32'(signed'(ins[15:0])); nxt.mw = 1'b1; end
            endcase
            if (rd == 0) nxt.rw = 1'b0;
        end
        return nxt;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic checkModel();
        checkOutput("ex_valid", ex_valid, model.valid);
        checkOutput("ex_alu_op", ex_alu_op, model.alu);
        checkOutput("ex_a", ex_a, model.a);
        checkOutput("ex_b", ex_b, model.b);
        checkOutput("ex_store_data", ex_store_data, model.sd);
        checkOutput("ex_rs", ex_rs, model.rs);
        checkOutput("ex_rt", ex_rt, model.rt);
        checkOutput("ex_rd", ex_rd, model.rd);
        checkOutput("ex_reg_write", ex_reg_write, model.rw);
        checkOutput("ex_mem_read", ex_mem_read, model.mr);
        checkOutput("ex_mem_write", ex_mem_write, model.mw);
        checkOutput("err_illegal", err_illegal, model_err);
    endtask

    // One decode cycle: drive, check combinational outputs, clock, check ID/EX
    task automatic applyStimulus(input logic [31:0] ins, input logic v, input logic f,
                                 input logic [31:0] ra, input logic [31:0] rb, output logic seen_stall);
        ex_t  nxt;
        logic exp_stall;
        @(negedge clk);
        instr = ins; instr_valid = v; flush = f; rs_data = ra; rt_data = rb;
        #1;
        nxt = modelStep(model, ins, v, f, ra, rb, exp_stall);
        checkOutput("stall", stall, exp_stall);
        checkOutput("rs_addr", rs_addr, ins[23:20]);
        checkOutput("rt_addr", rt_addr, ins[19:16]);
        seen_stall = stall;
        @(posedge clk);
        #1;
        if (v && !f && ins[31:28] >= 4'd11) model_err = 1'b1;
        model = nxt;
        checkModel();
    endtask

    vec_t vecs[17];

    initial begin
        logic        s;
        logic [31:0] rin, rra, rrb;
        logic        rv, rf;

        // Literal vectors, each entry's expectation accounts for the entry before it
        vecs[0]  = mkVec(enc(6,3,1,0,'hFFFE), 1,0, 5,0,   0,1,ALU_ADD, 5,32'hFFFFFFFE, 0, 1,3, 1,0,0);
        vecs[1]  = mkVec(enc(9,2,1,0,4),      1,0, 100,0, 0,1,ALU_ADD, 100,4, 0, 1,2, 1,1,0);
        vecs[2]  = mkVec(enc(0,4,2,5,0),      1,0, 7,8,   1,0,ALU_ADD, 0,0, 0, 0,0, 0,0,0);
        vecs[3]  = mkVec(enc(0,4,2,5,0),      1,0, 7,8,   0,1,ALU_ADD, 7,8, 8, 2,4, 1,0,0);
        vecs[4]  = mkVec(enc(9,2,1,0,8),      1,0, 0,0,   0,1,ALU_ADD, 0,8, 0, 1,2, 1,1,0);
        vecs[5]  = mkVec(enc(10,0,1,2,8),     1,0, 20,55, 1,0,ALU_ADD, 0,0, 0, 0,0, 0,0,0);
        vecs[6]  = mkVec(enc(10,0,1,2,8),     1,0, 20,55, 0,1,ALU_ADD, 20,8, 55, 1,0, 0,0,1);
        vecs[7]  = mkVec(enc(9,6,1,0,0),      1,0, 1,0,   0,1,ALU_ADD, 1,0, 0, 1,6, 1,1,0);
        vecs[8]  = mkVec(enc(10,0,1,7,8),     1,0, 3,9,   0,1,ALU_ADD, 3,8, 9, 1,0, 0,0,1);
        vecs[9]  = mkVec(enc(9,0,1,0,0),      1,0, 4,0,   0,1,ALU_ADD, 4,0, 0, 1,0, 0,1,0);
        vecs[10] = mkVec(enc(0,4,0,0,0),      1,0, 0,0,   0,1,ALU_ADD, 0,0, 0, 0,4, 1,0,0);
        vecs[11] = mkVec(enc(7,5,1,0,'h0123), 1,0, 'hF,0, 0,1,ALU_SLL, 'hF,3, 0, 1,5, 1,0,0);
        vecs[12] = mkVec(enc(8,1,1,0,'hFFFF), 1,0, 32'h80000000,0, 0,1,ALU_SRL, 32'h80000000,31, 0, 1,1, 1,0,0);
        vecs[13] = mkVec(enc(5,0,1,2,0),      1,0, 6,7,   0,1,ALU_MUL, 6,7, 7, 1,0, 0,0,0);
        vecs[14] = mkVec(enc(0,4,1,2,0),      0,0, 6,7,   0,0,ALU_ADD, 0,0, 0, 0,0, 0,0,0);
        vecs[15] = mkVec(enc(4,9,3,4,0),      1,1, 'hAA,'h55, 0,0,ALU_ADD, 0,0, 0, 0,0, 0,0,0);
        vecs[16] = mkVec(enc(4,9,3,4,0),      1,0, 'hAA,'h55, 0,1,ALU_COM, 'hAA,'h55, 'h55, 3,9, 1,0,0);

        model = '0;
        model_err = 1'b0;
        rst = 1'b1; instr = '0; instr_valid = 1'b0; flush = 1'b0; rs_data = '0; rt_data = '0;
        #1;
        checkOutput("reset_ex_valid", ex_valid, 0);
        checkOutput("reset_err", err_illegal, 0);
        checkOutput("reset_stall", stall, 0);
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] vector table");
        for (int i = 0; i < 17; i++) begin
            applyStimulus(vecs[i].ins, vecs[i].v, vecs[i].f, vecs[i].ra, vecs[i].rb, s);
            checkOutput($sformatf("vec%0d_stall", i), s, vecs[i].stl);
            checkOutput($sformatf("vec%0d_valid", i), ex_valid, vecs[i].vld);
            checkOutput($sformatf("vec%0d_alu", i), ex_alu_op, vecs[i].alu);
            checkOutput($sformatf("vec%0d_a", i), ex_a, vecs[i].a);
            checkOutput($sformatf("vec%0d_b", i), ex_b, vecs[i].b);
            checkOutput($sformatf("vec%0d_sd", i), ex_store_data, vecs[i].sd);
            checkOutput($sformatf("vec%0d_rs", i), ex_rs, vecs[i].rs);
            checkOutput($sformatf("vec%0d_rd", i), ex_rd, vecs[i].rd);
            checkOutput($sformatf("vec%0d_rw", i), ex_reg_write, vecs[i].rw);
            checkOutput($sformatf("vec%0d_mr", i), ex_mem_read, vecs[i].mr);
            checkOutput($sformatf("vec%0d_mw", i), ex_mem_write, vecs[i].mw);
            checkOutput($sformatf("vec%0d_err", i), err_illegal, 0);
        end

        $display("[TB] load then two dependent ops");
        applyStimulus(enc(9,2,1,0,0), 1,0, 0,0, s);
        applyStimulus(enc(0,3,2,2,0), 1,0, 1,1, s);
        checkOutput("chain_first_stall", s, 1);
        applyStimulus(enc(0,3,2,2,0), 1,0, 1,1, s);
        checkOutput("chain_first_issue", s, 0);
        checkOutput("chain_first_valid", ex_valid, 1);
        applyStimulus(enc(0,4,2,3,0), 1,0, 1,2, s);
        checkOutput("chain_second_stall", s, 0);

        $display("[TB] illegal opcode");
        applyStimulus(enc(12,1,1,1,0), 1,1, 0,0, s);
        checkOutput("illegal_flushed_err", err_illegal, 0);
        applyStimulus(enc(12,1,1,1,0), 1,0, 0,0, s);
        checkOutput("illegal_err", err_illegal, 1);
        checkOutput("illegal_bubble", ex_valid, 0);
        applyStimulus(enc(6,1,1,0,1), 1,0, 0,0, s);
        checkOutput("illegal_err_held", err_illegal, 1);

        $display("[TB] reset during a stall");
        applyStimulus(enc(9,2,1,0,0), 1,0, 0,0, s);
        @(negedge clk);
        instr = enc(0,4,2,5,0); instr_valid = 1'b1; flush = 1'b0;
        #1;
        checkOutput("pre_reset_stall", stall, 1);
        rst = 1'b1;
        #1;
        checkOutput("mid_reset_stall", stall, 0);
        checkOutput("mid_reset_valid", ex_valid, 0);
        checkOutput("mid_reset_mem_read", ex_mem_read, 0);
        checkOutput("mid_reset_rd", ex_rd, 0);
        checkOutput("mid_reset_err", err_illegal, 0);
        model = '0;
        model_err = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] random traffic");
        last_stall = 1'b0;
        rin = '0; rv = 1'b0;
        for (int c = 0; c < 600; c++) begin
            if (!last_stall) begin
                if ($urandom_range(0, 9) < 8)
                    rin = enc($urandom_range(0, 10), $urandom_range(0, 3), $urandom_range(0, 3),
                              $urandom_range(0, 3), $urandom);
                else
                    rin = enc($urandom_range(11, 15), $urandom_range(0, 3), $urandom_range(0, 3),
                              $urandom_range(0, 3), $urandom);
                rv = ($urandom_range(0, 9) != 0);
            end
            rf  = ($urandom_range(0, 9) == 0);
            rra = $urandom;
            rrb = $urandom;
            applyStimulus(rin, rv, rf, rra, rrb, last_stall);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- Instruction decode stage: the producer side of the ALU op interface.
- Takes a fetched 32-bit instruction, reads the register file, and produces ALU op, operands and control. These are registered into the ID/EX pipeline register that feeds the execute stage and ALU.
- Detects load-use hazards, stalling fetch and inserting bubbles; accepts flush from branch resolution.

Parameters:
- DSIZE, 32, datapath width; must match the ALU.
- RBITS, 4, register address width (16 registers; r0 reads zero).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- instr  in  32  instruction from IF/ID register
- instr_valid  in  1  instr is a real instruction (0 = bubble)
- flush  in  1  kill instruction being decoded (taken branch)
- rs_addr  out  RBITS  regfile read address A, combinational = instr[23:20]
- rt_addr  out  RBITS  regfile read address B, combinational = instr[19:16]
- rs_data  in  DSIZE  regfile read data A, same cycle
- rt_data  in  DSIZE  regfile read data B, same cycle
- stall  out  1  combinational; fetch and IF/ID must hold
- ex_valid  out  1  ID/EX holds a live instruction
- ex_alu_op  out  3  ALU op code (ADD/SUB/AND/XOR/SLL/SRL/COM/MUL macros)
- ex_a  out  DSIZE  ALU operand a
- ex_b  out  DSIZE  ALU operand b
- ex_store_data  out  DSIZE  rt_data, for SW
- ex_rs, ex_rt, ex_rd  out  RBITS each  register numbers, for forwarding/hazard
- ex_reg_write, ex_mem_read, ex_mem_write  out  1 each  control
- err_illegal  out  1  sticky illegal-opcode flag

Behaviour:
- Format: op=instr[31:28], rd=[27:24], rs=[23:20], rt=[19:16], imm=[15:0].
- Opcode map:
  - 0 ADD, 1 SUB, 2 AND, 3 XOR, 4 COM, 5 MUL: R-type; a=rs_data, b=rt_data, reg_write=1.
  - 6 ADDI: a=rs_data, b=sign-extended imm, alu ADD.
  - 7 SLLI, 8 SRLI: a=rs_data, b=zero-extended imm[4:0], alu SLL/SRL.
  - 9 LW: alu ADD, a=rs_data, b=sext imm, mem_read=1, reg_write=1.
  - 10 SW: alu ADD, a=rs_data, b=sext imm, mem_write=1, reg_write=0, store_data=rt_data.
  - 11-15 illegal: decoded as bubble; err_illegal set.
- rd==0 forces reg_write=0.
- Source use: rs is used by all legal ops; rt is used by R-type and SW only.
- Latency: one cycle, decode in cycle N, ID/EX outputs valid after edge N+1.
- Hazard (combinational, via hazard_unit): stall=1 when all of:
  - instr_valid & legal op & !flush
  - ex_valid & ex_mem_read & ex_rd!=0
  - ex_rd equals a used source (rs, or rt when used)
- On stall: ID/EX loads a bubble (ex_valid=0, all control 0); upstream holds instr. Next cycle the LW has moved on and the condition clears, so a load-use costs exactly 1 cycle.
- flush has priority over stall: stall=0, ID/EX loads a bubble.
- Bubble: ex_valid, ex_reg_write, ex_mem_read, ex_mem_write = 0. Data fields are don't-care, but are cleared to 0 to aid debug.
- err_illegal: set on the edge where instr_valid & !flush & op>=11; cleared only by rst.
- Reset (async, immediate): all ex_* = 0, err_illegal = 0. stall is combinational and is 0 because ex_valid=0.
- Reset mid-stall: pipeline empties and stall drops the same cycle rst asserts.
- Back-to-back LW then dependent op then dependent op: only the first dependent op stalls.

Decomposition:
- Shared define file (already holds DSIZE and ALU op macros) gains instruction opcode macros (OP_ADD..OP_SW) and field bit positions.
- Sub-module hazard_unit: purely combinational load-use compare. Inputs: decoded rs/rt/use flags, ex_rd, ex_mem_read, ex_valid, flush, instr_valid. Output: stall.
- id_stage contains the decoder, operand muxing and the ID/EX register.

Test Plan:
- Reset asserted mid-traffic -> all ex_* and err_illegal 0 asynchronously; stall 0.
- ADDI r3,r1,-2 with rs_data=5 -> next cycle ex_valid=1, alu ADD, ex_a=5, ex_b=0xFFFFFFFE, ex_rd=3, ex_reg_write=1.
- LW r2,4(r1) then ADD r4,r2,r5 -> stall=1 for exactly one cycle; bubble in ID/EX; ADD issues the following cycle with ex_rs=2.
- LW r0,0(r1) then ADD r4,r0,r0 -> no stall; the LW's ex_reg_write=0.
- SW r2,8(r1) following LW r2 -> stall (rt used); SW following LW r6 with rt=r7 -> no stall.
- Opcode 0xC with instr_valid=1 -> bubble, err_illegal=1 and held; the same opcode with flush=1 -> err_illegal unchanged.
